// File: rtl/spi_aes_frame_ctrl.sv
// spi_aes_frame_ctrl: sits behind the SPI receive stage.
// The first KF frames after reset or a key reload build the cipher key.
// Every later frame is one 128-bit plaintext block. The block drives the
// AES core with that block and parks the result for the SPI shift-out side.
module spi_aes_frame_ctrl #(
    parameter int Nk       = 4,
    parameter int Nr       = 10,
    parameter int datasize = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [datasize-1:0] rx_data,
    input  logic                key_reload,
    output logic [Nk*32-1:0]    aes_key,
    output logic [127:0]        aes_in,
    output logic                aes_start,
    input  logic                aes_done,
    input  logic [127:0]        aes_out,
    output logic [127:0]        tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                key_ready,
    output logic                busy,
    output logic                overrun
);

    localparam int KW = Nk * 32;
    localparam int KF = (KW + 127) / 128;

    // Reject configurations the frame and key slicing cannot handle.
    // Nr belongs to the AES core and is only range-checked here.
    if (datasize != 128 || (Nk != 4 && Nk != 6 && Nk != 8) || Nr < 1) begin : g_bad_cfg
        $error("spi_aes_frame_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_KEY   = 3'd0,
        S_PT    = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_idx;
    logic            w_idx_nxt;
    logic [KW-1:0]   r_key;
    logic [KW-1:0]   w_key_nxt;
    logic [127:0]    r_in;
    logic [127:0]    w_in_nxt;
    logic [127:0]    r_tx;
    logic [127:0]    w_tx_nxt;
    logic            r_key_ready;
    logic            w_key_ready_nxt;
    logic            r_overrun;
    logic            w_overrun_nxt;
    logic            r_start;
    logic            r_tx_valid;
    logic            r_busy;

    // Next-state logic and next values for the data and flag registers.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_key_nxt       = r_key;
        w_in_nxt        = r_in;
        w_tx_nxt        = r_tx;
        w_key_ready_nxt = r_key_ready;
        w_overrun_nxt   = r_overrun;
        case (r_state)
            S_KEY: begin
                if (key_reload) begin
                    // A reload here restarts key collection from the first frame.
                    w_idx_nxt = 1'b0;
                end else if (rx_valid) begin
                    // Key bit counted i from the MSB sits in frame i/128.
                    // Each frame supplies its bits starting at the frame MSB.
                    for (int i = 0; i < KW; i++) begin
                        if ((i / 128) == int'(r_idx)) begin
                            w_key_nxt[KW-1-i] = rx_data[datasize-1-(i % 128)];
                        end else begin
                            w_key_nxt[KW-1-i] = r_key[KW-1-i];
                        end
                    end
                    if (int'(r_idx) == KF - 1) begin
                        w_key_ready_nxt = 1'b1;
                        w_idx_nxt       = 1'b0;
                        w_state_nxt     = S_PT;
                    end else begin
                        w_idx_nxt = 1'b1;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            S_PT: begin
                // A frame takes priority over a key reload in the same cycle.
                if (rx_valid) begin
                    w_in_nxt    = rx_data;
                    w_state_nxt = S_START;
                end else if (key_reload) begin
                    w_key_ready_nxt = 1'b0;
                    w_idx_nxt       = 1'b0;
                    w_state_nxt     = S_KEY;
                end else begin
                    w_state_nxt = S_PT;
                end
            end
            S_START: begin
                w_state_nxt   = S_WAIT;
                w_overrun_nxt = r_overrun | rx_valid;
            end
            S_WAIT: begin
                w_overrun_nxt = r_overrun | rx_valid;
                if (aes_done) begin
                    w_tx_nxt    = aes_out;
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_OUT: begin
                w_overrun_nxt = r_overrun | rx_valid;
                if (tx_ready) begin
                    w_state_nxt = S_PT;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            default: begin
                w_state_nxt = S_KEY;
                w_idx_nxt   = 1'b0;
            end
        endcase
    end

    // State, datapath and registered status outputs, all cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_KEY;
            r_idx       <= 1'b0;
            r_key       <= '0;
            r_in        <= 128'd0;
            r_tx        <= 128'd0;
            r_key_ready <= 1'b0;
            r_overrun   <= 1'b0;
            r_start     <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_key       <= w_key_nxt;
            r_in        <= w_in_nxt;
            r_tx        <= w_tx_nxt;
            r_key_ready <= w_key_ready_nxt;
            r_overrun   <= w_overrun_nxt;
            r_start     <= (w_state_nxt == S_START);
            r_tx_valid  <= (w_state_nxt == S_OUT);
            r_busy      <= (w_state_nxt == S_START) || (w_state_nxt == S_WAIT) ||
                           (w_state_nxt == S_OUT);
        end
    end

    assign aes_key   = r_key;
    assign aes_in    = r_in;
    assign aes_start = r_start;
    assign tx_data   = r_tx;
    assign tx_valid  = r_tx_valid;
    assign key_ready = r_key_ready;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_spi_aes_frame_ctrl.sv
// Bench for spi_aes_frame_ctrl: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_spi_aes_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Nk = 4 instance, model-checked
    logic         rst = 1'b1, rx_valid = 1'b0, key_reload = 1'b0;
    logic [127:0] rx_data = 128'd0;
    logic [127:0] aes_key, aes_in, tx_data;
    logic         aes_start, tx_valid, key_ready, busy, overrun;
    logic         aes_done = 1'b0, tx_ready = 1'b0;
    logic [127:0] aes_out = 128'd0;

    // Nk = 6 instance, directed only
    logic         rst6 = 1'b1, rx_valid6 = 1'b0, key_reload6 = 1'b0;
    logic [127:0] rx_data6 = 128'd0;
    logic [191:0] aes_key6;
    logic [127:0] aes_in6, tx_data6;
    logic         aes_start6, tx_valid6, key_ready6, busy6, overrun6;
    logic         aes_done6 = 1'b0, tx_ready6 = 1'b0;
    logic [127:0] aes_out6 = 128'd0;

    spi_aes_frame_ctrl #(.Nk(4), .Nr(10), .datasize(128)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .key_reload(key_reload), .aes_key(aes_key), .aes_in(aes_in),
        .aes_start(aes_start), .aes_done(aes_done), .aes_out(aes_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .key_ready(key_ready), .busy(busy), .overrun(overrun)
    );

    spi_aes_frame_ctrl #(.Nk(6), .Nr(12), .datasize(128)) dut6 (
        .clk(clk), .rst(rst6), .rx_valid(rx_valid6), .rx_data(rx_data6),
        .key_reload(key_reload6), .aes_key(aes_key6), .aes_in(aes_in6),
        .aes_start(aes_start6), .aes_done(aes_done6), .aes_out(aes_out6),
        .tx_data(tx_data6), .tx_valid(tx_valid6), .tx_ready(tx_ready6),
        .key_ready(key_ready6), .busy(busy6), .overrun(overrun6)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model of the Nk=4 instance.
    // A block is "launched" (start pulse visible), then "in flight",
    // then "held" for the shift-out side.
    logic         m_keyed = 1'b0, m_launch = 1'b0, m_flight = 1'b0, m_held = 1'b0, m_ovr = 1'b0;
    logic [127:0] m_key = 128'd0, m_in = 128'd0, m_tx = 128'd0;
    bit           cmp_en = 1'b1;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_keyed = 1'b0; m_launch = 1'b0; m_flight = 1'b0; m_held = 1'b0; m_ovr = 1'b0;
            m_key = 128'd0; m_in = 128'd0; m_tx = 128'd0;
        end else if (m_launch || m_flight || m_held) begin
            if (rx_valid) m_ovr = 1'b1;
            if (m_launch) begin
                m_launch = 1'b0; m_flight = 1'b1;
            end else if (m_flight) begin
                if (aes_done) begin m_tx = aes_out; m_flight = 1'b0; m_held = 1'b1; end
            end else begin
                if (tx_ready) m_held = 1'b0;
            end
        end else if (!m_keyed) begin
            // one frame carries the whole 128-bit key; a reload just restarts
            if (!key_reload && rx_valid) begin m_key = rx_data; m_keyed = 1'b1; end
        end else begin
            if (rx_valid) begin m_in = rx_data; m_launch = 1'b1; end
            else if (key_reload) m_keyed = 1'b0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("aes_key",   aes_key,   m_key);
            chk("aes_in",    aes_in,    m_in);
            chk("aes_start", aes_start, m_launch);
            chk("tx_data",   tx_data,   m_tx);
            chk("tx_valid",  tx_valid,  m_held);
            chk("key_ready", key_ready, m_keyed);
            chk("busy",      busy,      m_launch | m_flight | m_held);
            chk("overrun",   overrun,   m_ovr);
        end
    end

    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'hfedcba9876543210f0e1d2c3b4a59687;
    localparam logic [127:0] K6A  = 128'h8e73b0f7da0e6452c810f32b809079e5;

    initial begin
        // reset state
        step(); step();
        chk("rst key_ready", key_ready, 1'b0);
        chk("rst aes_key",   aes_key,   128'd0);
        chk("rst tx_valid",  tx_valid,  1'b0);
        chk("rst busy",      busy,      1'b0);
        rst = 1'b0;

        // key frame
        rx_valid = 1'b1; rx_data = KEY; step(); rx_valid = 1'b0;
        chk("key loaded", key_ready, 1'b1);
        chk("key value",  aes_key,   KEY);

        // plaintext frame: start one cycle later, single pulse
        rx_valid = 1'b1; rx_data = PT; step(); rx_valid = 1'b0; rx_data = 128'd0;
        chk("start pulse", aes_start, 1'b1);
        chk("aes_in",      aes_in,    PT);
        step();
        chk("start single", aes_start, 1'b0);
        chk("busy wait",    busy,      1'b1);

        // frame during WAIT is dropped
        rx_valid = 1'b1; rx_data = 128'hdeadbeefdeadbeefdeadbeefdeadbeef; step(); rx_valid = 1'b0;
        chk("overrun set",   overrun, 1'b1);
        chk("aes_in kept",   aes_in,  PT);

        aes_done = 1'b1; aes_out = CT; step(); aes_done = 1'b0; aes_out = 128'd0;
        chk("tx_valid up", tx_valid, 1'b1);
        chk("tx_data",     tx_data,  CT);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("tx hold data",  tx_data,  CT);
            chk("tx hold valid", tx_valid, 1'b1);
        end
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        chk("tx_valid down", tx_valid, 1'b0);
        chk("idle busy",     busy,     1'b0);
        chk("overrun stays", overrun,  1'b1);

        // frame and reload together: frame wins
        rx_valid = 1'b1; key_reload = 1'b1; rx_data = PT; step();
        rx_valid = 1'b0; key_reload = 1'b0;
        chk("both start",     aes_start, 1'b1);
        chk("both key_ready", key_ready, 1'b1);
        step();
        aes_done = 1'b1; aes_out = CT; step(); aes_done = 1'b0;
        tx_ready = 1'b1; step(); tx_ready = 1'b0;

        // reload alone then new key
        key_reload = 1'b1; step(); key_reload = 1'b0;
        chk("reload key_ready", key_ready, 1'b0);
        chk("reload key kept",  aes_key,   KEY);
        rx_valid = 1'b1; rx_data = KEY2; step(); rx_valid = 1'b0;
        chk("reload key2", aes_key,   KEY2);
        chk("reload rdy",  key_ready, 1'b1);

        // reset while waiting, late done ignored
        rx_valid = 1'b1; rx_data = PT; step(); rx_valid = 1'b0; step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid rst aes_in",   aes_in,    128'd0);
        chk("mid rst aes_key",  aes_key,   128'd0);
        chk("mid rst overrun",  overrun,   1'b0);
        chk("mid rst busy",     busy,      1'b0);
        chk("mid rst keyready", key_ready, 1'b0);
        aes_done = 1'b1; aes_out = CT; step(); aes_done = 1'b0;
        chk("late done tx_valid", tx_valid, 1'b0);
        chk("late done tx_data",  tx_data,  128'd0);

        // Nk = 6: two frames, low half of the second frame discarded
        step(); rst6 = 1'b0;
        rx_valid6 = 1'b1; rx_data6 = K6A; step(); rx_valid6 = 1'b0;
        chk("nk6 after f0", key_ready6, 1'b0);
        rx_valid6 = 1'b1; rx_data6 = {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555}; step();
        rx_valid6 = 1'b0;
        chk("nk6 ready", key_ready6, 1'b1);
        chk("nk6 key",   aes_key6,   {K6A, 64'hAAAAAAAAAAAAAAAA});

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            rx_valid   = ($urandom_range(0, 9) < 3);
            rx_data    = {$urandom, $urandom, $urandom, $urandom};
            key_reload = ($urandom_range(0, 99) < 8);
            aes_done   = m_flight ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            aes_out    = {$urandom, $urandom, $urandom, $urandom};
            tx_ready   = ($urandom_range(0, 9) < 4);
            step();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_aes_frame_ctrl.md
Name: spi_aes_frame_ctrl

Overview:
- Downstream of the SPI receive stage. Consumes each completed SPI frame: a strobe plus the parallel frame word.
- Assembles the cipher key from the first frame(s) and treats every later frame as one 128-bit data block.
- For each block it launches the AES core, waits for the result, and holds that result in a transmit buffer until the SPI shift-out side accepts it.

Parameters:
- Nk, 4: key length in 32-bit words (4/6/8).
- Nr, 10: round count; passed through to the core, no internal use.
- datasize, 128: SPI frame width in bits. Must equal 128.
- KF, (Nk*32+127)/128: derived; number of frames needed to carry the key (1 or 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete frame
- rx_data  in  datasize  received frame, MSB = first bit on the wire
- key_reload  in  1  one-cycle request to load a new key
- aes_key  out  Nk*32  assembled key to AES core
- aes_in  out  128  data block to AES core
- aes_start  out  1  one-cycle launch pulse to AES core
- aes_done  in  1  AES core result-valid strobe
- aes_out  in  128  AES core result
- tx_data  out  128  result held for the SPI shift-out side
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  shift-out side accepts tx_data
- key_ready  out  1  key fully loaded
- busy  out  1  high in S_START, S_WAIT, S_OUT
- overrun  out  1  sticky: a frame was dropped

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - State goes to S_KEY with frame index 0.
  - All outputs and registers go to 0: aes_key, aes_in, tx_data, aes_start, tx_valid, key_ready, busy, overrun.
  - Reset mid-operation abandons any in-flight block. An aes_done arriving after reset is ignored.
- S_KEY, on rx_valid:
  - Frame k (0-based) fills key bits [Nk*32-1-128k : max(0, Nk*32-128(k+1))], taking the MSBs of rx_data.
  - For Nk=6, frame 1 contributes rx_data[127:64]; rx_data[63:0] is discarded.
  - After frame KF-1: key_ready=1, go to S_PT.
- S_PT:
  - On rx_valid: aes_in <= rx_data, go to S_START.
  - key_reload (with no rx_valid in the same cycle): key_ready=0, frame index 0, go to S_KEY. aes_key keeps its old value until overwritten.
  - rx_valid and key_reload in the same cycle: rx_valid wins; the key_reload is ignored.
- S_START: aes_start=1 for exactly one cycle, then go to S_WAIT. Latency from rx_valid to aes_start is 1 cycle.
- S_WAIT:
  - On aes_done: tx_data <= aes_out, tx_valid=1, go to S_OUT.
  - No timeout; the block waits indefinitely.
- S_OUT:
  - tx_valid stays high and tx_data stays stable until tx_ready is sampled high.
  - That cycle: tx_valid <= 0, go to S_PT.
  - tx_ready is ignored when tx_valid=0.
- Overrun:
  - rx_valid in S_START, S_WAIT or S_OUT drops the frame and sets overrun=1.
  - overrun clears only on rst.
- aes_done outside S_WAIT is ignored.
- key_reload outside S_PT is ignored. Exception: in S_KEY it restarts the frame index at 0.
- aes_key and aes_in are stable from aes_start until aes_done.

Test Plan:
- Nk=4: rst, then frame 000102030405060708090a0b0c0d0e0f -> key_ready=1, aes_key equals that value.
- Then frame 00112233445566778899aabbccddeeff -> aes_in equals it; aes_start high exactly 1 cycle, 1 cycle after rx_valid. Model aes_done with aes_out=69c4e0d86a7b0430d8cdb78070b4c55a -> tx_valid=1, tx_data equals that value. Hold tx_ready=0 for 5 cycles -> tx_data stable. tx_ready=1 -> tx_valid=0, state S_PT.
- Nk=6: two key frames; second frame = AAAA...A (all A) with low 64 bits = 5555... -> aes_key[63:0]=AAAAAAAAAAAAAAAA, the 5555 bits are discarded.
- rx_valid while in S_WAIT -> frame dropped, overrun=1, aes_in unchanged. Pulse aes_done -> normal completion, overrun stays 1.
- In S_PT, rx_valid and key_reload together -> block launched, key_ready stays 1. Later key_reload alone -> key_ready=0, next frame reloads the key.
- rst asserted in S_WAIT -> all outputs 0, state S_KEY. Late aes_done -> tx_valid stays 0.
